// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Parametrised Fibonacci/Galois LFSR with zero-seed guard and period measurement (optional: LFSR_PERIOD_CHECK_EN)
module lfsr_gen #(
  parameter int WIDTH        = 4,
  parameter int DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             seed_err,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len
);

  // Fibonacci tap masks: bit (n-1) set for each tap n of a primitive polynomial.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAP_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAP      = TAP_FULL[WIDTH-1:0];
  // Galois feedback constant derived from the same polynomial (or its reciprocal).
  localparam logic [WIDTH-1:0] GAL      = {TAP[WIDTH-2:0], 1'b1};
  localparam logic [WIDTH-1:0] DSEED    = WIDTH'(DEFAULT_SEED);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("lfsr_gen: WIDTH must be in 2..16");
  end

  if (DSEED == '0) begin : g_seed_check
    $error("lfsr_gen: DEFAULT_SEED truncated to WIDTH must be non-zero");
  end

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] next_out;
  logic [WIDTH-1:0] load_val;

  // Next value in both forms, plus the guarded seed (zero replaced by the default).
  always_comb begin
    fib_next = {out[WIDTH-2:0], ^(out & TAP)};
    gal_next = {out[WIDTH-2:0], 1'b0} ^ (out[WIDTH-1] ? GAL : '0);
    next_out = mode ? gal_next : fib_next;
    load_val = (seed == '0) ? DSEED : seed;
  end

  // LFSR state and zero-seed pulse; load wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= DSEED;
      seed_err <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      if (load) begin
        out      <= load_val;
        seed_err <= (seed == '0);
      end else if (en) begin
        out <= next_out;
      end
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             run_mode_q, run_mode_d;

  // Period FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= DSEED;
      cnt_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      run_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      done_q     <= done_d;
      run_mode_q <= run_mode_d;
    end
  end

  // Count steps from the start value; a mode change restarts the measurement at the current value.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    done_d     = 1'b0;
    run_mode_d = run_mode_q;
    if (load) begin
      state_d = IDLE;
      start_d = load_val;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d    = RUN;
            cnt_d      = ONE;
            run_mode_d = mode;
          end
        end
        RUN: begin
          if (mode != run_mode_q) begin
            // A step in the same cycle becomes the first step of the new measurement.
            start_d    = out;
            run_mode_d = mode;
            if (en) begin
              cnt_d = ONE;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (en) begin
            if (next_out == start_q) begin
              len_d  = cnt_q + ONE;
              done_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period_done = done_q;
  assign period_len  = len_q;
`else
  assign period_done = 1'b0;
  assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - Self-checking bench for lfsr_gen (W4 directed+random, W8/W16 free-running)
module tb_lfsr_gen;
`ifdef LFSR_PERIOD_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, en4, load4, mode4;
  logic [3:0] seed4, out4, len4;
  logic       err4, done4;
  logic       rst_fr, en_fr;
  logic [7:0] out8, len8;
  logic       err8, done8;
  logic [15:0] out16, len16;
  logic        err16, done16;

  lfsr_gen #(.WIDTH(4), .DEFAULT_SEED(1)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .load(load4), .seed(seed4), .mode(mode4),
    .out(out4), .seed_err(err4), .period_done(done4), .period_len(len4));

  lfsr_gen #(.WIDTH(8), .DEFAULT_SEED(1)) u8 (
    .clk(clk), .rst(rst_fr), .en(en_fr), .load(1'b0), .seed(8'h00), .mode(1'b0),
    .out(out8), .seed_err(err8), .period_done(done8), .period_len(len8));

  lfsr_gen #(.WIDTH(16), .DEFAULT_SEED(16'hACE1)) u16 (
    .clk(clk), .rst(rst_fr), .en(en_fr), .load(1'b0), .seed(16'h0000), .mode(1'b1),
    .out(out16), .seed_err(err16), .period_done(done16), .period_len(len16));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit seen16 = 1'b0;
  bit zero_seen = 1'b0;

  int m_out[3], m_start[3], m_cnt[3], m_len[3], m_mref[3];
  bit m_done[3], m_err[3];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 16;
  endfunction

  function automatic int dseed(input int k);
    return (k == 2) ? 'hACE1 : 1;
  endfunction

  function automatic int taps(input int w);
    case (w)
      4:       return 'hC;
      8:       return 'hB8;
      default: return 'hD008;
    endcase
  endfunction

  // One LFSR step computed from the polynomial: shift-with-parity or multiply-by-x mod p.
  function automatic int lfsr_step(input int v, input int w, input bit md);
    int mask = (1 << w) - 1;
    int t = taps(w);
    int fb = 0;
    int nv;
    if (!md) begin
      for (int i = 0; i < w; i++) if (t[i]) fb ^= v[i];
      return ((v << 1) | fb) & mask;
    end
    nv = v << 1;
    if ((nv >> w) & 1) nv = (nv & mask) ^ (((t << 1) | 1) & mask);
    return nv & mask;
  endfunction

  task automatic model_step(input int k, input bit r, input bit l, input bit e,
                            input int s, input bit md);
    if (r) begin
      m_out[k] = dseed(k); m_start[k] = dseed(k); m_cnt[k] = 0;
      m_len[k] = 0; m_done[k] = 0; m_err[k] = 0; m_mref[k] = md;
      return;
    end
    m_done[k] = 0;
    m_err[k] = 0;
    if (l) begin
      m_err[k] = (s == 0);
      m_out[k] = (s == 0) ? dseed(k) : s;
      m_start[k] = m_out[k];
      m_cnt[k] = 0;
      m_mref[k] = md;
      return;
    end
    if (md != m_mref[k]) begin
      m_start[k] = m_out[k];
      m_cnt[k] = 0;
      m_mref[k] = md;
    end
    if (e) begin
      m_out[k] = lfsr_step(m_out[k], wid(k), md);
      m_cnt[k]++;
      if (m_out[k] == m_start[k]) begin
        m_len[k] = m_cnt[k];
        m_done[k] = 1;
        m_cnt[k] = 0;
      end
    end
  endtask

  // Reference model advances on every rising edge from the inputs the DUTs see.
  initial forever begin
    @(posedge clk);
    model_step(0, rst4, load4, en4, int'(seed4), mode4);
    model_step(1, rst_fr, 1'b0, en_fr, 0, 1'b0);
    model_step(2, rst_fr, 1'b0, en_fr, 0, 1'b1);
    cyc++;
  end

  // Compare all outputs on the falling edge.
  initial forever begin
    int d_out[3], d_err[3], d_done[3], d_len[3];
    @(negedge clk);
    if (cyc > 0) begin
      d_out  = '{int'(out4), int'(out8), int'(out16)};
      d_err  = '{int'(err4), int'(err8), int'(err16)};
      d_done = '{int'(done4), int'(done8), int'(done16)};
      d_len  = '{int'(len4), int'(len8), int'(len16)};
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("w%0d_out", wid(k)), d_out[k], m_out[k]);
        chk($sformatf("w%0d_seed_err", wid(k)), d_err[k], int'(m_err[k]));
        chk($sformatf("w%0d_period_done", wid(k)), d_done[k], PC ? int'(m_done[k]) : 0);
        chk($sformatf("w%0d_period_len", wid(k)), d_len[k], PC ? m_len[k] : 0);
        if (d_out[k] == 0) zero_seen = 1'b1;
      end
      if (done16) seen16 = 1'b1;
    end
  end

  task automatic drv(input logic r, input logic l, input logic e,
                     input logic [3:0] s, input logic m);
    rst4 = r; load4 = l; en4 = e; seed4 = s; mode4 = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_f[15];
    int seq_g[15];
    logic md;
    logic [3:0] s;
    seq_f = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    seq_g = '{2, 4, 8, 9, 11, 15, 7, 14, 5, 10, 13, 3, 6, 12, 1};
    rst4 = 1'b1; load4 = 1'b0; en4 = 1'b0; seed4 = 4'd0; mode4 = 1'b0;
    rst_fr = 1'b1; en_fr = 1'b0;

    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    rst_fr = 1'b0; en_fr = 1'b1;
    chk("reset_out", out4, 1);
    chk("reset_seed_err", err4, 0);
    chk("reset_period_done", done4, 0);
    chk("reset_period_len", len4, 0);

    // Fibonacci from seed 1.
    drv(0, 1, 0, 4'd1, 0);
    for (int i = 0; i < 15; i++) begin
      drv(0, 0, 1, 0, 0);
      chk($sformatf("fib_seq%0d", i), out4, seq_f[i]);
    end
    chk("fib_done", done4, PC);
    chk("fib_len", len4, PC ? 15 : 0);

    // Galois from seed 1.
    drv(0, 1, 0, 4'd1, 1);
    for (int i = 0; i < 15; i++) begin
      drv(0, 0, 1, 0, 1);
      chk($sformatf("gal_seq%0d", i), out4, seq_g[i]);
    end
    chk("gal_len", len4, PC ? 15 : 0);

    // Zero seed is replaced by the default and flagged for one cycle.
    drv(0, 1, 0, 4'd0, 0);
    chk("zero_seed_out", out4, 1);
    chk("zero_seed_err", err4, 1);
    drv(0, 0, 0, 0, 0);
    chk("zero_seed_err_clear", err4, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 0, 0);
      chk($sformatf("zero_seed_seq%0d", i), out4, seq_f[i]);
    end

    // en toggling from seed 6: advances only on enabled cycles.
    drv(0, 1, 0, 4'd6, 0);
    for (int i = 0; i < 30; i++) begin
      drv(0, 0, (i % 2 == 0), 0, 0);
      chk($sformatf("toggle_seq%0d", i), out4, seq_f[(4 + i / 2 + 1) % 15]);
    end
    chk("toggle_len", len4, PC ? 15 : 0);

    // load+en mid-run loads only; reset mid-run clears the measurement.
    drv(0, 1, 0, 4'd1, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 0, 0);
    chk("midrun_out", out4, 6);
    drv(0, 1, 1, 4'd5, 0);
    chk("load_en_out", out4, 5);
    drv(0, 0, 1, 0, 0);
    chk("load_en_next", out4, 11);
    drv(0, 0, 1, 0, 0);
    drv(1, 0, 1, 0, 0);
    chk("midrun_rst_out", out4, 1);
    chk("midrun_rst_len", len4, 0);

    // Randomised phase checked by the model every cycle.
    md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) md = ~md;
      s = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drv($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 75, s, md);
    end
    drv(0, 0, 0, 0, md);

    // Let the free-running W16 instance complete one full period.
    for (int i = 0; i < 65600 && !seen16; i++) @(posedge clk);
    #2;
    chk("w16_done_seen", seen16, PC);
    chk("w16_len", len16, PC ? 65535 : 0);
    chk("w8_len", len8, PC ? 255 : 0);
    chk("model_w8_len", m_len[1], 255);
    chk("model_w16_len", m_len[2], 65535);
    chk("out_nonzero", zero_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
